// File: rtl/rotary_input_conditioner_pkg.sv
// Shared constants and the quadrature legality test for the rotary input conditioner.
// Imported by the interface, the per-contact debouncer and the top.
package rotary_cond_pkg;

   localparam int                       ILLEGAL_CNT_W      = 8;
   localparam logic [ILLEGAL_CNT_W-1:0] ILLEGAL_CNT_MAX    = 8'd255;
   localparam logic                     IDLE_LEVEL_DEFAULT = 1'b1;

   // Both phases of a quadrature pair moving on the same edge is not a Gray step.
   function automatic logic is_illegal_step(input logic [1:0] prev, input logic [1:0] curr);
      return (prev ^ curr) == 2'b11;
   endfunction

endpackage

// File: rtl/rotary_input_conditioner_if.sv
// Bundle of raw contacts, clean levels and illegal-step status between the board side and the conditioner.
// The master side drives contacts and the clear strobe; the slave side (the conditioner) drives the rest.
interface rotary_cond_if
   import rotary_cond_pkg::*;
#(
   parameter int CHANNELS = 2
);

   logic [2*CHANNELS-1:0]             rotary_raw;
   logic [2*CHANNELS-1:0]             rotary_clean;
   logic [CHANNELS-1:0]               illegal_step;
   logic [ILLEGAL_CNT_W*CHANNELS-1:0] illegal_count;
   logic                              clear_counts;

   modport master (
      output rotary_raw,
      output clear_counts,
      input  rotary_clean,
      input  illegal_step,
      input  illegal_count
   );

   modport slave (
      input  rotary_raw,
      input  clear_counts,
      output rotary_clean,
      output illegal_step,
      output illegal_count
   );

endinterface

// File: rtl/rotary_input_conditioner_debounce_bit.sv
// One mechanical contact: SYNC_STAGES-flop synchroniser followed by a restart-on-equality debounce counter.
// A stable change reaches o_clean on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th edge counting the sampling edge.
module debounce_bit #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_clean
);

   localparam int             CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_clean;
   logic                   w_synced;

   assign w_synced = r_sync[SYNC_STAGES-1];
   assign o_clean  = r_clean;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      end
   end

   // Any cycle where the synced level agrees with the output restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_clean <= IDLE_LEVEL;
      end else if (w_synced == r_clean) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_clean <= w_synced;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/rotary_input_conditioner.sv
// Per-channel rotary front end: debounced clean levels, illegal quadrature step pulse and saturating count.
// illegal_step is high for the cycle after a pair's clean bits both update; clear wins before increment.
module rotary_input_conditioner
   import rotary_cond_pkg::*;
#(
   parameter int   CHANNELS        = 2,
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_LEVEL      = IDLE_LEVEL_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   rotary_cond_if.slave bus
);

   logic [2*CHANNELS-1:0]                  w_clean;
   logic [2*CHANNELS-1:0]                  r_prev_clean;
   logic [CHANNELS-1:0]                    w_illegal;
   logic [CHANNELS-1:0][ILLEGAL_CNT_W-1:0] r_count;

   for (genvar b = 0; b < 2*CHANNELS; b++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_LEVEL      (IDLE_LEVEL)
      ) u_db (
         .clk     (clk),
         .reset   (reset),
         .i_raw   (bus.rotary_raw[b]),
         .o_clean (w_clean[b])
      );
   end

   // prev_clean shares the clean reset value, so reset itself never looks like a step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev_clean <= {(2*CHANNELS){IDLE_LEVEL}};
      end else begin
         r_prev_clean <= w_clean;
      end
   end

   always_comb begin
      w_illegal = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_illegal[c] = is_illegal_step(r_prev_clean[2*c +: 2], w_clean[2*c +: 2]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (bus.clear_counts) begin
               r_count[c] <= w_illegal[c] ? ILLEGAL_CNT_W'(1) : '0;
            end else if (w_illegal[c] && (r_count[c] != ILLEGAL_CNT_MAX)) begin
               r_count[c] <= r_count[c] + 1'b1;
            end
         end
      end
   end

   assign bus.rotary_clean  = w_clean;
   assign bus.illegal_step  = w_illegal;
   assign bus.illegal_count = r_count;

endmodule

// File: tb/tb_rotary_input_conditioner.sv
// Directed bench for rotary_input_conditioner with CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_rotary_input_conditioner;
   import rotary_cond_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   rotary_cond_if #(.CHANNELS(2)) bus ();

   rotary_input_conditioner #(
      .CHANNELS        (2),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .IDLE_LEVEL      (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0]  raw;
      logic [3:0]  clean;
      logic [1:0]  step;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl [8];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0]  prev;
      logic        bad;
      logic [15:0] cnt_now;

      // CW walk on channel 0, then illegal jumps on channel 1 and on both.
      tbl[0] = '{raw: 4'b1110, clean: 4'b1110, step: 2'b00, cnt: 16'h0000};
      tbl[1] = '{raw: 4'b1100, clean: 4'b1100, step: 2'b00, cnt: 16'h0000};
      tbl[2] = '{raw: 4'b1101, clean: 4'b1101, step: 2'b00, cnt: 16'h0000};
      tbl[3] = '{raw: 4'b1111, clean: 4'b1111, step: 2'b00, cnt: 16'h0000};
      tbl[4] = '{raw: 4'b0011, clean: 4'b0011, step: 2'b10, cnt: 16'h0100};
      tbl[5] = '{raw: 4'b1111, clean: 4'b1111, step: 2'b10, cnt: 16'h0200};
      tbl[6] = '{raw: 4'b0000, clean: 4'b0000, step: 2'b11, cnt: 16'h0301};
      tbl[7] = '{raw: 4'b1111, clean: 4'b1111, step: 2'b11, cnt: 16'h0402};

      // 1. reset with raw low
      reset = 1'b1;
      bus.rotary_raw   = 4'b0000;
      bus.clear_counts = 1'b0;
      cycles(1);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_clean_%0d", i), 16'(bus.rotary_clean), 16'h000F);
         check($sformatf("rst_step_%0d", i), 16'(bus.illegal_step), 16'h0000);
         check($sformatf("rst_count_%0d", i), bus.illegal_count, 16'h0000);
         cycles(1);
      end
      reset = 1'b0;
      cycles(5);
      check("release_clean_edge5", 16'(bus.rotary_clean), 16'h000F);
      cycles(1);
      check("release_clean_edge6", 16'(bus.rotary_clean), 16'h0000);
      check("release_step", 16'(bus.illegal_step), 16'h0003);
      cycles(1);
      check("release_count", bus.illegal_count, 16'h0101);
      bus.clear_counts = 1'b1;
      cycles(1);
      bus.clear_counts = 1'b0;
      check("clear_count", bus.illegal_count, 16'h0000);
      bus.rotary_raw = 4'b1111;
      cycles(6);
      check("restore_clean", 16'(bus.rotary_clean), 16'h000F);
      cycles(1);
      bus.clear_counts = 1'b1;
      cycles(1);
      bus.clear_counts = 1'b0;
      check("clear_count2", bus.illegal_count, 16'h0000);

      // 2. single bit fall on bit 0
      bus.rotary_raw = 4'b1110;
      cycles(5);
      check("bit0_edge5", 16'(bus.rotary_clean), 16'h000F);
      cycles(1);
      check("bit0_edge6", 16'(bus.rotary_clean), 16'h000E);
      check("bit0_step", 16'(bus.illegal_step), 16'h0000);
      cycles(4);
      check("bit0_held", 16'(bus.rotary_clean), 16'h000E);
      bus.rotary_raw = 4'b1111;
      cycles(6);
      check("bit0_back", 16'(bus.rotary_clean), 16'h000F);

      // 3. glitches shorter than the debounce window, including a restart
      bad = 1'b0;
      bus.rotary_raw = 4'b1011;
      for (int i = 0; i < 3; i++) begin cycles(1); bad |= (bus.rotary_clean != 4'b1111); end
      bus.rotary_raw = 4'b1111;
      cycles(1); bad |= (bus.rotary_clean != 4'b1111);
      bus.rotary_raw = 4'b1011;
      for (int i = 0; i < 3; i++) begin cycles(1); bad |= (bus.rotary_clean != 4'b1111); end
      bus.rotary_raw = 4'b1111;
      for (int i = 0; i < 8; i++) begin cycles(1); bad |= (bus.rotary_clean != 4'b1111); end
      check("glitch_clean_stable", 16'(bad), 16'h0000);
      check("glitch_cnt_zero", 16'(dut.g_bit[2].u_db.r_cnt), 16'h0000);

      // 4. table: legal walk and illegal jumps
      prev = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         bus.rotary_raw = tbl[i].raw;
         cycles(5);
         check($sformatf("vec%0d_hold", i), 16'(bus.rotary_clean), 16'(prev));
         cycles(1);
         check($sformatf("vec%0d_clean", i), 16'(bus.rotary_clean), 16'(tbl[i].clean));
         check($sformatf("vec%0d_step", i), 16'(bus.illegal_step), 16'(tbl[i].step));
         cycles(1);
         check($sformatf("vec%0d_step_end", i), 16'(bus.illegal_step), 16'h0000);
         cycles(1);
         check($sformatf("vec%0d_count", i), bus.illegal_count, tbl[i].cnt);
         prev = tbl[i].clean;
      end

      // 5. saturation of the channel 1 counter (starts at 4)
      cnt_now = 16'h0004;
      for (int i = 0; i < 300; i++) begin
         bus.rotary_raw = {~bus.rotary_raw[3:2], bus.rotary_raw[1:0]};
         cycles(7);
         if (cnt_now < 16'd255) cnt_now++;
         if (i == 249 || i == 250 || i == 299)
            check($sformatf("sat_count_%0d", i), 16'(bus.illegal_count[15:8]), cnt_now);
      end
      check("sat_count_full", bus.illegal_count, 16'hFF02);
      check("sat_clean", 16'(bus.rotary_clean), 16'h000F);

      // 6. clear coincident with a pulse, then reset mid-debounce
      bus.rotary_raw = 4'b1100;
      cycles(6);
      check("clr_pulse", 16'(bus.illegal_step), 16'h0001);
      bus.clear_counts = 1'b1;
      cycles(1);
      bus.clear_counts = 1'b0;
      check("clr_and_inc", bus.illegal_count, 16'h0001);
      bus.rotary_raw = 4'b1110;
      cycles(4);
      check("pre_rst_clean", 16'(bus.rotary_clean), 16'h000C);
      reset = 1'b1;
      #1;
      check("async_rst_clean", 16'(bus.rotary_clean), 16'h000F);
      check("async_rst_step", 16'(bus.illegal_step), 16'h0000);
      check("async_rst_count", bus.illegal_count, 16'h0000);
      cycles(2);
      reset = 1'b0;
      bus.rotary_raw = 4'b1111;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         bad |= (bus.illegal_step != 2'b00) || (bus.rotary_clean != 4'b1111);
      end
      check("post_rst_quiet", 16'(bad), 16'h0000);
      check("post_rst_count", bus.illegal_count, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
